sa_skew_feeder: RTL and testbench

Operand feeder for the FP16 systolic array. It accepts a stream of N-lane FP16 row vectors over a valid/ready handshake and drives them into the array edge. Lane i is delayed by i cycles, giving the diagonal wavefront the MAC grid expects. Bubbles stay lane-aligned, and after the programmed number of vectors the pipe is flushed with +0.0 before `done`.

---
 rtl/sa_skew_feeder.sv | 139 +++++++++++++
 tb/tb_sa_skew_feeder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_skew_feeder.sv
// Operand feeder for the FP16 systolic array: accepts N-lane row vectors and
// skews lane i by i cycles, flushing the pipe with bubbles before done.
module sa_skew_feeder #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_valid,
  output logic                busy,
  output logic                done
);

  localparam int unsigned FC_W       = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned FLUSH_LAST = (N > 1) ? N - 2 : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [LEN_W-1:0]  cnt_q, cnt_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [FC_W-1:0]   fcnt_q, fcnt_n;
  logic              zl_q, zl_n;
  logic              ready_q, ready_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              hs;

  // ready is only ever high in FEED below the latched length
  assign hs = in_valid & ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      fcnt_q  <= '0;
      zl_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      len_q   <= len_n;
      fcnt_q  <= fcnt_n;
      zl_q    <= zl_n;
      ready_q <= ready_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    len_n   = len_q;
    fcnt_n  = fcnt_q;
    zl_n    = 1'b0;
    done_n  = zl_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_n   = len;
            cnt_n   = '0;
            state_n = S_FEED;
          end else begin
            zl_n = 1'b1;
          end
        end
      end
      S_FEED: begin
        if (hs) begin
          cnt_n = cnt_q + LEN_W'(1);
          if (cnt_n == len_q) begin
            if (N == 1) begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = S_FLUSH;
              fcnt_n  = '0;
            end
          end
        end
      end
      S_FLUSH: begin
        if (fcnt_q == FC_W'(FLUSH_LAST)) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          fcnt_n = fcnt_q + FC_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    ready_n = (state_n == S_FEED) && (cnt_n < len_n);
    busy_n  = (state_n != S_IDLE);
  end

  assign in_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Lane i is a chain of i+1 registers; bubbles carry data 0 so invalid slots read +0.0
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] d_q [0:i];
    logic [i:0]        v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= i; j++) d_q[j] <= '0;
        v_q <= '0;
      end else begin
        d_q[0] <= hs ? in_data[i*DATA_W +: DATA_W] : '0;
        v_q[0] <= hs;
        for (int j = 1; j <= i; j++) begin
          d_q[j] <= d_q[j-1];
          v_q[j] <= v_q[j-1];
        end
      end
    end

    assign out_data[i*DATA_W +: DATA_W] = d_q[i];
    assign out_valid[i]                 = v_q[i];
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench for sa_skew_feeder: the driver predicts per-lane arrival
// cycles and done cycles, a monitor compares every cycle's outputs.
module tb_sa_skew_feeder;
  localparam int unsigned N      = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [LEN_W-1:0]    len;
  logic                in_valid;
  logic                in_ready;
  logic [N*DATA_W-1:0] in_data;
  logic [N*DATA_W-1:0] out_data;
  logic [N-1:0]        out_valid;
  logic                busy;
  logic                done;

  typedef struct {
    int unsigned       cyc;
    logic [DATA_W-1:0] d;
  } exp_t;

  exp_t        lq [N][$];
  int unsigned dq [$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  sa_skew_feeder #(.N(N), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare each lane and done against the scoreboard after every edge
  logic [DATA_W-1:0] mon_d;
  exp_t              mon_e;
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      mon_d = out_data[i*DATA_W +: DATA_W];
      while (lq[i].size() > 0 && lq[i][0].cyc < cyc) begin
        chk($sformatf("lane%0d_missing", i), 64'(cyc), 64'(lq[i][0].cyc));
        void'(lq[i].pop_front());
      end
      if (out_valid[i]) begin
        if (lq[i].size() == 0) begin
          chk($sformatf("lane%0d_unexpected_valid", i), 64'(1), 64'(0));
        end else begin
          mon_e = lq[i].pop_front();
          chk($sformatf("lane%0d_cycle", i), 64'(cyc), 64'(mon_e.cyc));
          chk($sformatf("lane%0d_data", i), 64'(mon_d), 64'(mon_e.d));
        end
      end else begin
        chk($sformatf("lane%0d_idle_zero", i), 64'(mon_d), 64'(0));
      end
    end
    while (dq.size() > 0 && dq[0] < cyc) begin
      chk("done_missing", 64'(cyc), 64'(dq[0]));
      void'(dq.pop_front());
    end
    if (done) begin
      if (dq.size() == 0) begin
        chk("done_unexpected", 64'(1), 64'(0));
      end else begin
        chk("done_cycle", 64'(cyc), 64'(dq.pop_front()));
      end
      chk("busy_low_with_done", 64'(busy), 64'(0));
    end
  end

  task automatic push_vec(input logic [N*DATA_W-1:0] v, input int unsigned e);
    exp_t x;
    for (int i = 0; i < N; i++) begin
      x.cyc = e + i;
      x.d   = v[i*DATA_W +: DATA_W];
      lq[i].push_back(x);
    end
  endtask

  function automatic logic [N*DATA_W-1:0] pattern(input int k);
    logic [N*DATA_W-1:0] v;
    for (int i = 0; i < N; i++) v[i*DATA_W +: DATA_W] = DATA_W'(16'h3C00 + 16*k + i);
    return v;
  endfunction

  function automatic logic [N*DATA_W-1:0] rand_vec();
    return {$urandom, $urandom};
  endfunction

  task automatic wait_done();
    int t = 0;
    in_valid = 1'b0;
    while (dq.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (dq.size() != 0) begin
      chk("done_timeout", 64'(0), 64'(1));
      dq.delete();
    end
  endtask

  // Caller is at a negedge; gap idle cycles precede the start pulse
  task automatic run_job(input int l, input bit pat, input int gap_after, input int bub_pct,
                         input bit mid_start, input bit hold, input int gap);
    int          k = 0;
    bit          gapped = 0;
    bit          v;
    int unsigned e;
    logic [N*DATA_W-1:0] vec;
    repeat (gap) @(negedge clk);
    start    = 1'b1;
    len      = LEN_W'(l);
    in_valid = 1'($urandom);
    in_data  = rand_vec();
    e = cyc + 1;
    if (l == 0) begin
      dq.push_back(e + 1);
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        chk("len0_busy", 64'(busy), 64'(0));
        chk("len0_in_ready", 64'(in_ready), 64'(0));
        chk("len0_out_valid", 64'(out_valid), 64'(0));
      end
      wait_done();
      return;
    end
    while (k < l) begin
      @(negedge clk);
      start = 1'b0;
      chk("in_ready_feed", 64'(in_ready), 64'(1));
      chk("busy_feed", 64'(busy), 64'(1));
      if (mid_start && k == 1) begin
        start = 1'b1;
        len   = LEN_W'(7);
      end
      v = ($urandom_range(0, 99) >= bub_pct);
      if (k == gap_after && !gapped) begin
        v = 1'b0;
        gapped = 1'b1;
      end
      vec = pat ? pattern(k) : rand_vec();
      in_valid = v;
      in_data  = vec;
      if (v) begin
        e = cyc + 1;
        push_vec(vec, e);
        k++;
        if (k == l) dq.push_back(e + N - 1);
      end
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = hold;
    chk("in_ready_after_last", 64'(in_ready), 64'(0));
    if (hold) begin
      repeat (2) begin
        @(negedge clk);
        chk("in_ready_hold", 64'(in_ready), 64'(0));
      end
    end
    wait_done();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_data"}, out_data, 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
  endtask

  task automatic reset_mid_job();
    logic [N*DATA_W-1:0] vec;
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(3);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      vec      = pattern(k);
      in_data  = vec;
      push_vec(vec, cyc + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'($urandom);
    in_data  = rand_vec();
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) lq[i].delete();
    dq.delete();
    #1;
    chk_all_zero("midjob_reset");
    @(negedge clk);
    chk_all_zero("midjob_reset_hold");
    start = 1'b0;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk_all_zero("after_abort");
    run_job(1, 1'b1, -1, 0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset_idle");

    run_job(3, 1'b1, -1, 0, 1'b0, 1'b0, 0);  // back-to-back pattern
    run_job(2, 1'b1, 1, 0, 1'b0, 1'b0, 0);   // one bubble between V0 and V1
    run_job(0, 1'b0, -1, 0, 1'b0, 1'b0, 2);  // empty job
    run_job(3, 1'b1, -1, 0, 1'b1, 1'b1, 1);  // mid-FEED start and held in_valid
    reset_mid_job();

    for (int j = 0; j < 20; j++) begin
      run_job(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 7)),
              1'b0, int'($urandom_range(0, 6)) - 1, int'($urandom_range(0, 50)),
              1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    repeat (10) @(negedge clk);
    for (int i = 0; i < N; i++) chk($sformatf("lane%0d_drained", i), 64'(lq[i].size()), 64'(0));
    chk("done_drained", 64'(dq.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
